// File: rtl/apbDecode_package.sv
// uBlockA APB responder address map, target enumeration and offset decoder.
// Pure combinational helpers only; no latency or flow control of its own.
package apbDecode_package;

    localparam int unsigned MEMORYA_WORDS = 19;

    localparam logic [11:0] UBLOCKA_AREG_LO   = 12'h000;
    localparam logic [11:0] UBLOCKA_AREG_HI   = 12'h004;
    localparam logic [11:0] UBLOCKA_ASIZE     = 12'h008;
    localparam logic [11:0] UBLOCKA_MEMA_BASE = 12'h100;

    typedef enum logic [2:0] {
        TGT_AREG_LO,
        TGT_AREG_HI,
        TGT_ASIZE,
        TGT_MEMA_LO,
        TGT_MEMA_HI,
        TGT_ERR
    } ublockaTargetT;

    // memA words occupy 8-byte slots from the base; bit 2 selects the hi dword.
    function automatic ublockaTargetT ublockaDecode(input logic [11:0] off,
                                                    input int unsigned memWords);
        ublockaTargetT tgt;
        tgt = TGT_ERR;
        if (off[1:0] == 2'b00) begin
            if (off == UBLOCKA_AREG_LO) begin
                tgt = TGT_AREG_LO;
            end else if (off == UBLOCKA_AREG_HI) begin
                tgt = TGT_AREG_HI;
            end else if (off == UBLOCKA_ASIZE) begin
                tgt = TGT_ASIZE;
            end else if ((off[11:8] == UBLOCKA_MEMA_BASE[11:8]) &&
                         ({27'd0, off[7:3]} < memWords)) begin
                tgt = off[2] ? TGT_MEMA_HI : TGT_MEMA_LO;
            end
        end
        return tgt;
    endfunction

endpackage

// File: rtl/ublocka_apb_target.sv
// APB3 completer for uBlockA: aReg, aSizeReg and memory A with staged writes and snapshot reads.
// Zero wait states except memA lo reads (MEM_RD_LATENCY+1 waits); psel drop mid-transfer aborts.
module ublocka_apb_target
    import apbDecode_package::*;
#(
    parameter int          MEM_RD_LATENCY = 1,
    parameter int unsigned MEMA_WORDS     = MEMORYA_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic [36:0] a_reg,
    output logic [28:0] a_size_reg,
    output logic        mem_a_cs,
    output logic        mem_a_we,
    output logic [4:0]  mem_a_addr,
    output logic [62:0] mem_a_wdata,
    input  logic [62:0] mem_a_rdata
);

    typedef enum logic [1:0] {IDLE, MEM_RD, RESP} stateT;

    localparam logic [1:0] RD_LAT = 2'(MEM_RD_LATENCY);

    stateT         state;
    stateT         stateNext;
    ublockaTargetT tgtD;
    ublockaTargetT tgtQ;
    logic          writeQ;
    logic [31:0]   wdataQ;
    logic [4:0]    wordQ;
    logic [1:0]    latCnt;
    logic [31:0]   aRegStage;
    logic [31:0]   memAStage;
    logic [4:0]    aRegShadow;
    logic [30:0]   memAShadow;
    logic [31:0]   prdataQ;
    logic          setup;
    logic          rdDone;
    logic          commit;
    logic          unusedPaddr;

    assign unusedPaddr = ^paddr[31:12];

    assign tgtD   = ublockaDecode(paddr[11:0], MEMA_WORDS);
    assign setup  = (state == IDLE) && psel && !penable;
    assign rdDone = (state == MEM_RD) && psel && (latCnt == RD_LAT);
    assign commit = (state == RESP) && psel;

    assign prdata      = prdataQ;
    assign mem_a_addr  = wordQ;
    assign mem_a_wdata = {wdataQ[30:0], memAStage};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        pready    = 1'b0;
        pslverr   = 1'b0;
        mem_a_cs  = 1'b0;
        mem_a_we  = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    stateNext = (!pwrite && (tgtD == TGT_MEMA_LO)) ? MEM_RD : RESP;
                end
            end
            MEM_RD: begin
                mem_a_cs = psel && (latCnt == 2'd0);
                if (!psel) begin
                    stateNext = IDLE;
                end else if (latCnt == RD_LAT) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                pready    = 1'b1;
                pslverr   = (tgtQ == TGT_ERR);
                mem_a_cs  = psel && writeQ && (tgtQ == TGT_MEMA_HI);
                mem_a_we  = psel && writeQ && (tgtQ == TGT_MEMA_HI);
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request capture and read data selection happen on the setup edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgtQ    <= TGT_AREG_LO;
            writeQ  <= 1'b0;
            wdataQ  <= '0;
            wordQ   <= '0;
            latCnt  <= '0;
            prdataQ <= '0;
        end else begin
            if (setup) begin
                tgtQ   <= tgtD;
                writeQ <= pwrite;
                wdataQ <= pwdata;
                wordQ  <= paddr[7:3];
                latCnt <= '0;
                if (pwrite) begin
                    prdataQ <= '0;
                end else begin
                    case (tgtD)
                        TGT_AREG_LO: prdataQ <= a_reg[31:0];
                        TGT_AREG_HI: prdataQ <= {27'd0, aRegShadow};
                        TGT_ASIZE:   prdataQ <= {3'd0, a_size_reg};
                        TGT_MEMA_HI: prdataQ <= {1'b0, memAShadow};
                        TGT_MEMA_LO: prdataQ <= prdataQ;
                        default:     prdataQ <= '0;
                    endcase
                end
            end else if (state == MEM_RD) begin
                latCnt <= latCnt + 2'd1;
                if (rdDone) begin
                    prdataQ <= mem_a_rdata[31:0];
                end
            end
        end
    end

    // Architectural state only moves on a non-aborted RESP edge (or SRAM read completion).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            a_size_reg <= '0;
            aRegStage  <= '0;
            memAStage  <= '0;
            aRegShadow <= '0;
            memAShadow <= '0;
        end else begin
            if (rdDone) begin
                memAShadow <= mem_a_rdata[62:32];
            end
            if (commit) begin
                if (writeQ) begin
                    case (tgtQ)
                        TGT_AREG_LO: aRegStage  <= wdataQ;
                        TGT_AREG_HI: a_reg      <= {wdataQ[4:0], aRegStage};
                        TGT_ASIZE:   a_size_reg <= wdataQ[28:0];
                        TGT_MEMA_LO: memAStage  <= wdataQ;
                        default:     ;
                    endcase
                end else if (tgtQ == TGT_AREG_LO) begin
                    aRegShadow <= a_reg[36:32];
                end
            end
        end
    end

endmodule
